// File: rtl/gpnae_batch_dispatcher.sv
// Batch front-end for the GPNAE activation core: buffers mode-tagged samples, streams them to the
// core with bounded in-flight requests, returns results in order. Optional perf counters: GPNAE_PERF_CNT_EN.
module gpnae_batch_dispatcher #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_LINES    = 5,
    parameter int unsigned CONTROL_WIDTH = 2,
    parameter int unsigned MAX_INFLIGHT  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DATA_WIDTH-1:0]    signal_i,
    input  logic                     wr_en_i,
    input  logic [CONTROL_WIDTH-1:0] control_word_i,
    input  logic                     last_i,
    input  logic [ADDR_LINES-1:0]    terms_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     idle_o,
    output logic                     core_valid_o,
    input  logic                     core_ready_i,
    output logic [DATA_WIDTH-1:0]    core_data_o,
    output logic [CONTROL_WIDTH-1:0] core_mode_o,
    input  logic                     core_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]    core_rsp_data_i,
    output logic [DATA_WIDTH-1:0]    final_result_o,
    output logic                     done_o,
    output logic                     batch_done_o,
    output logic                     err_o
`ifdef GPNAE_PERF_CNT_EN
    ,
    output logic [31:0]              perf_load_cyc_o,
    output logic [31:0]              perf_busy_cyc_o,
    output logic [31:0]              perf_stall_cyc_o
`endif
);
    localparam int unsigned DEPTH = 2 ** ADDR_LINES;
    localparam int unsigned CNT_W = ADDR_LINES + 1;
    localparam int unsigned ENT_W = CONTROL_WIDTH + DATA_WIDTH;
    localparam int unsigned INF_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DISP  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]      wcnt_q, wcnt_d, rcnt_q, rcnt_d, target_q, target_d;
    logic [INF_W-1:0]      inflight_q, inflight_d;
    logic                  full_q, full_d, empty_q, empty_d, idle_q, idle_d;
    logic                  valid_q, valid_d, done_q, done_d, bdone_q, bdone_d, err_q, err_d;
    logic [ENT_W-1:0]      head_q, head_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [ENT_W-1:0]      mem_q [DEPTH];

    logic                  wr_ok, pop, rsp_ok, close, tgt_miss;
    logic [CNT_W-1:0]      tgt, wcnt_nx;

`ifdef GPNAE_PERF_CNT_EN
    logic [31:0] pload_q, pload_d, pbusy_q, pbusy_d, pstall_q, pstall_d;
    logic        perf_clr;
`endif

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        target_d   = target_q;
        result_d   = result_q;
        done_d     = 1'b0;
        bdone_d    = 1'b0;
        err_d      = err_q;

        wr_ok    = wr_en_i && ((state_q == S_IDLE) || (state_q == S_LOAD)) && !full_q
                   && (control_word_i != '0);
        pop      = valid_q && core_ready_i;
        rsp_ok   = core_rsp_valid_i && (inflight_q != '0);
        // A new batch starts counting from zero against the freshly presented target.
        tgt      = (state_q == S_IDLE) ? CNT_W'(terms_i) : target_q;
        wcnt_nx  = ((state_q == S_IDLE) ? '0 : wcnt_q) + CNT_W'(wr_ok);
        close    = last_i || ((tgt != '0) && (wcnt_nx == tgt));
        tgt_miss = (tgt != '0) && (wcnt_nx != tgt);

        if ((wr_en_i && !wr_ok) || (core_rsp_valid_i && !rsp_ok)) err_d = 1'b1;
        if (wr_ok) wptr_d = wptr_q + CNT_W'(1);
        if (pop)   rptr_d = rptr_q + CNT_W'(1);
        inflight_d = inflight_q + INF_W'(pop) - INF_W'(rsp_ok);
        if (rsp_ok) begin
            result_d = core_rsp_data_i;
            done_d   = 1'b1;
            rcnt_d   = rcnt_q + CNT_W'(1);
        end

        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[ADDR_LINES-1:0] == rptr_d[ADDR_LINES-1:0])
                  && (wptr_d[ADDR_LINES] != rptr_d[ADDR_LINES]);

        case (state_q)
            S_IDLE: begin
                if (wr_ok) begin
                    target_d = tgt;
                    wcnt_d   = wcnt_nx;
                    rcnt_d   = '0;
                    state_d  = close ? S_DISP : S_LOAD;
                    if (close && tgt_miss) err_d = 1'b1;
                end
            end
            S_LOAD: begin
                wcnt_d = wcnt_nx;
                if (close) begin
                    state_d = S_DISP;
                    if (tgt_miss) err_d = 1'b1;
                end
            end
            default: begin
                if (rsp_ok && ((rcnt_q + CNT_W'(1)) == wcnt_q)) begin
                    bdone_d = 1'b1;
                    state_d = S_IDLE;
                end else if ((state_q == S_DISP) && empty_d) begin
                    state_d = S_DRAIN;
                end
            end
        endcase

        // Head is registered; a write landing on the next read slot bypasses the array.
        if (wr_ok && (wptr_q[ADDR_LINES-1:0] == rptr_d[ADDR_LINES-1:0]))
            head_d = {control_word_i, signal_i};
        else
            head_d = mem_q[rptr_d[ADDR_LINES-1:0]];

        valid_d = (state_d == S_DISP) && !empty_d && (inflight_d < INF_W'(MAX_INFLIGHT));
        idle_d  = (state_d == S_IDLE);

`ifdef GPNAE_PERF_CNT_EN
        pload_d  = pload_q;
        pbusy_d  = pbusy_q;
        pstall_d = pstall_q;
        perf_clr = (state_q == S_IDLE) && wr_ok;
        if (perf_clr) begin
            pload_d  = '0;
            pbusy_d  = '0;
            pstall_d = '0;
        end else begin
            if ((state_q == S_LOAD) && (pload_q != '1)) pload_d = pload_q + 32'd1;
            if (((state_q == S_DISP) || (state_q == S_DRAIN)) && (pbusy_q != '1))
                pbusy_d = pbusy_q + 32'd1;
            if (valid_q && !core_ready_i && (pstall_q != '1)) pstall_d = pstall_q + 32'd1;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            target_q   <= '0;
            inflight_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            idle_q     <= 1'b1;
            valid_q    <= 1'b0;
            head_q     <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            bdone_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef GPNAE_PERF_CNT_EN
            pload_q    <= '0;
            pbusy_q    <= '0;
            pstall_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            target_q   <= target_d;
            inflight_q <= inflight_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            idle_q     <= idle_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            result_q   <= result_d;
            done_q     <= done_d;
            bdone_q    <= bdone_d;
            err_q      <= err_d;
`ifdef GPNAE_PERF_CNT_EN
            pload_q    <= pload_d;
            pbusy_q    <= pbusy_d;
            pstall_q   <= pstall_d;
`endif
        end
    end

    // Sample storage needs no reset; pointers define validity.
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wptr_q[ADDR_LINES-1:0]] <= {control_word_i, signal_i};
    end

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign idle_o         = idle_q;
    assign core_valid_o   = valid_q;
    assign core_data_o    = head_q[DATA_WIDTH-1:0];
    assign core_mode_o    = head_q[ENT_W-1:DATA_WIDTH];
    assign final_result_o = result_q;
    assign done_o         = done_q;
    assign batch_done_o   = bdone_q;
    assign err_o          = err_q;
`ifdef GPNAE_PERF_CNT_EN
    assign perf_load_cyc_o  = pload_q;
    assign perf_busy_cyc_o  = pbusy_q;
    assign perf_stall_cyc_o = pstall_q;
`endif

endmodule

// File: tb/tb_gpnae_batch_dispatcher.sv
// Randomized self-checking bench for gpnae_batch_dispatcher against a queue-based batch model.
// Perf counter checks are compiled in when GPNAE_PERF_CNT_EN is defined.
module tb_gpnae_batch_dispatcher;
    localparam int unsigned MI    = 4;
    localparam int unsigned DEPTH = 32;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] signal_i = '0;
    logic        wr_en_i = 1'b0;
    logic [1:0]  control_word_i = '0;
    logic        last_i = 1'b0;
    logic [4:0]  terms_i = '0;
    logic        full_o, empty_o, idle_o, core_valid_o;
    logic        core_ready_i = 1'b0;
    logic [31:0] core_data_o;
    logic [1:0]  core_mode_o;
    logic        core_rsp_valid_i = 1'b0;
    logic [31:0] core_rsp_data_i = '0;
    logic [31:0] final_result_o;
    logic        done_o, batch_done_o, err_o;
`ifdef GPNAE_PERF_CNT_EN
    logic [31:0] perf_load_cyc_o, perf_busy_cyc_o, perf_stall_cyc_o;
`endif

    gpnae_batch_dispatcher dut (
        .clk_i(clk_i), .rst_i(rst_i), .signal_i(signal_i), .wr_en_i(wr_en_i),
        .control_word_i(control_word_i), .last_i(last_i), .terms_i(terms_i),
        .full_o(full_o), .empty_o(empty_o), .idle_o(idle_o),
        .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
        .core_data_o(core_data_o), .core_mode_o(core_mode_o),
        .core_rsp_valid_i(core_rsp_valid_i), .core_rsp_data_i(core_rsp_data_i),
        .final_result_o(final_result_o), .done_o(done_o), .batch_done_o(batch_done_o),
        .err_o(err_o)
`ifdef GPNAE_PERF_CNT_EN
        , .perf_load_cyc_o(perf_load_cyc_o), .perf_busy_cyc_o(perf_busy_cyc_o),
        .perf_stall_cyc_o(perf_stall_cyc_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0, cyc = 0, pops = 0, dones = 0, bdones = 0;
    bit auto_rsp = 1'b0, rand_ready = 1'b0;
    int lat_lo = 2, lat_hi = 2;

    // Model: 0 = idle, 1 = collecting, 2 = running the batch
    int          m_state = 0, m_count = 0, m_target = 0, m_len = 0, m_results = 0;
    logic        m_err = 1'b0, exp_done = 1'b0, exp_bdone = 1'b0;
    logic [31:0] m_final = '0;
    int unsigned m_load = 0, m_busy = 0, m_stall = 0;
    logic [33:0] exp_req[$];
    logic [31:0] pend[$];
    int          pend_due[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic wr_ok;
        int   old;
        if (rand_ready) core_ready_i = ($urandom_range(0, 3) != 0);
        if (auto_rsp) begin
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                core_rsp_valid_i = 1'b1;
                core_rsp_data_i  = pend[0];
            end else begin
                core_rsp_valid_i = 1'b0;
                core_rsp_data_i  = $urandom;
            end
        end
        old = m_state;
        if (old == 1) m_load++;
        if (old == 2) m_busy++;
        if (core_valid_o && !core_ready_i) m_stall++;
        wr_ok = wr_en_i && (old != 2) && (exp_req.size() < DEPTH) && (control_word_i != 2'b00);
        if (wr_en_i && !wr_ok) m_err = 1'b1;
        exp_done  = 1'b0;
        exp_bdone = 1'b0;
        if (core_rsp_valid_i) begin
            if (pend.size() > 0) begin
                void'(pend.pop_front());
                void'(pend_due.pop_front());
                exp_done = 1'b1;
                m_final  = core_rsp_data_i;
                m_results++;
                if (m_results == m_len) begin
                    exp_bdone = 1'b1;
                    m_state   = 0;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        if (core_valid_o && core_ready_i) begin
            pops++;
            if (exp_req.size() > 0)
                check("req", 64'({core_mode_o, core_data_o}), 64'(exp_req.pop_front()));
            else
                check("spurious_req", 64'(core_valid_o), 64'(1'b0));
            pend.push_back(core_data_o);
            pend_due.push_back(cyc + $urandom_range(lat_hi, lat_lo));
        end
        if (wr_ok) begin
            if (old == 0) begin
                m_target  = int'(terms_i);
                m_count   = 0;
                m_results = 0;
                m_state   = 1;
                m_load    = 0;
                m_busy    = 0;
                m_stall   = 0;
            end
            exp_req.push_back({control_word_i, signal_i});
            m_count++;
        end
        if (m_state == 1 && (last_i || (m_target != 0 && m_count == m_target))) begin
            m_len   = m_count;
            m_state = 2;
            if (m_target != 0 && m_count != m_target) m_err = 1'b1;
        end

        @(posedge clk_i);
        #1;
        cyc++;
        if (done_o) dones++;
        if (batch_done_o) bdones++;
        check("done", 64'(done_o), 64'(exp_done));
        check("batch_done", 64'(batch_done_o), 64'(exp_bdone));
        check("final_result", 64'(final_result_o), 64'(m_final));
        check("err", 64'(err_o), 64'(m_err));
        check("empty", 64'(empty_o), 64'(exp_req.size() == 0));
        check("full", 64'(full_o), 64'(exp_req.size() == DEPTH));
        check("idle", 64'(idle_o), 64'(m_state == 0));
        check("core_valid", 64'(core_valid_o),
              64'((m_state == 2) && (exp_req.size() > 0) && (pend.size() < MI)));
`ifdef GPNAE_PERF_CNT_EN
        check("perf_load", 64'(perf_load_cyc_o), 64'(m_load));
        check("perf_busy", 64'(perf_busy_cyc_o), 64'(m_busy));
        check("perf_stall", 64'(perf_stall_cyc_o), 64'(m_stall));
`endif
    endtask

    task automatic wr(input logic [31:0] d, input logic [1:0] m, input logic l);
        wr_en_i = 1'b1; signal_i = d; control_word_i = m; last_i = l;
        step();
        wr_en_i = 1'b0; control_word_i = 2'b00; last_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((m_state != 0 || pend.size() > 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_budget", 64'(n < budget), 64'(1'b1));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        wr_en_i = 1'b0; last_i = 1'b0; core_rsp_valid_i = 1'b0; control_word_i = 2'b00;
        m_state = 0; m_count = 0; m_target = 0; m_len = 0; m_results = 0;
        m_err = 1'b0; m_final = '0; m_load = 0; m_busy = 0; m_stall = 0;
        exp_req.delete(); pend.delete(); pend_due.delete();
        @(posedge clk_i);
        #1;
        cyc++;
        check("rst_full", 64'(full_o), 64'(1'b0));
        check("rst_empty", 64'(empty_o), 64'(1'b1));
        check("rst_idle", 64'(idle_o), 64'(1'b1));
        check("rst_valid", 64'(core_valid_o), 64'(1'b0));
        check("rst_data", 64'({core_mode_o, core_data_o}), 64'(0));
        check("rst_final", 64'(final_result_o), 64'(0));
        check("rst_done", 64'({done_o, batch_done_o}), 64'(0));
        check("rst_err", 64'(err_o), 64'(1'b0));
        rst_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Mixed-mode batch with a two-cycle echoing core
        auto_rsp = 1; rand_ready = 0; core_ready_i = 1; lat_lo = 2; lat_hi = 2;
        terms_i = 5'd3; dones = 0; bdones = 0;
        wr(32'h3F80_0000, 2'b01, 1'b0);
        wr(32'hBF80_0000, 2'b10, 1'b0);
        wr(32'h4000_0000, 2'b11, 1'b0);
        drain(60);
        check("mix_dones", 64'(dones), 64'(3));
        check("mix_batch_done", 64'(bdones), 64'(1));
        check("mix_last_result", 64'(final_result_o), 64'(32'h4000_0000));
        step();
        check("mix_idle_after", 64'(idle_o), 64'(1'b1));

        // last_i with the first write gives a one-sample batch
        terms_i = 5'd0; dones = 0; bdones = 0;
        wr($urandom, 2'b10, 1'b1);
        drain(30);
        check("one_dones", 64'(dones), 64'(1));
        check("one_batch_done", 64'(bdones), 64'(1));
        wr($urandom, 2'b00, 1'b0);
        check("mode0_err", 64'(err_o), 64'(1'b1));

        // Fill to full, overflow, then close with last_i alone
        do_reset();
        terms_i = 5'd0; pops = 0; dones = 0;
        for (int i = 0; i < 32; i++) wr($urandom, 2'($urandom_range(1, 3)), 1'b0);
        check("fill_full", 64'(full_o), 64'(1'b1));
        wr($urandom, 2'b01, 1'b0);
        check("fill_overflow_err", 64'(err_o), 64'(1'b1));
        last_i = 1'b1;
        step();
        last_i = 1'b0;
        drain(400);
        check("fill_pops", 64'(pops), 64'(32));
        check("fill_dones", 64'(dones), 64'(32));

        // In-flight limit with a silent core
        do_reset();
        auto_rsp = 0; core_ready_i = 1; terms_i = 5'd8; pops = 0;
        for (int i = 0; i < 8; i++) wr($urandom, 2'($urandom_range(1, 3)), 1'b0);
        for (int i = 0; i < 8; i++) step();
        check("bp_pops", 64'(pops), 64'(4));
        check("bp_valid_low", 64'(core_valid_o), 64'(1'b0));
        core_rsp_valid_i = 1'b1;
        core_rsp_data_i  = pend[0];
        step();
        core_rsp_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("bp_one_more_pop", 64'(pops), 64'(5));
        auto_rsp = 1;
        drain(200);

        // Reset while dispatching, then a stray response
        terms_i = 5'd4; auto_rsp = 0; core_ready_i = 1;
        for (int i = 0; i < 4; i++) wr($urandom, 2'($urandom_range(1, 3)), 1'b0);
        step();
        step();
        do_reset();
        core_rsp_valid_i = 1'b1;
        core_rsp_data_i  = $urandom;
        step();
        core_rsp_valid_i = 1'b0;
        check("stray_rsp_err", 64'(err_o), 64'(1'b1));

        // Randomized batches
        do_reset();
        auto_rsp = 1; rand_ready = 1; lat_lo = 1; lat_hi = 4;
        for (int b = 0; b < 30; b++) begin
            int n;
            terms_i = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                while ($urandom_range(0, 3) == 0) step();
                wr($urandom, ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                   1'(i == n - 1));
            end
            drain(300);
        end

`ifdef GPNAE_PERF_CNT_EN
        // Stall counter over seven refused cycles
        do_reset();
        rand_ready = 0; core_ready_i = 0; lat_lo = 2; lat_hi = 2; terms_i = 5'd5;
        for (int i = 0; i < 5; i++) wr($urandom, 2'($urandom_range(1, 3)), 1'b0);
        for (int i = 0; i < 7; i++) step();
        check("perf_stall_7", 64'(perf_stall_cyc_o), 64'(7));
        core_ready_i = 1;
        drain(100);
        check("perf_stall_hold", 64'(perf_stall_cyc_o), 64'(7));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
